alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Parametrised ALU operand-select stage for the EX side of the pipelined RISC-V core. It picks the A and B operands from register data, PC, immediate or constant sources. It forwards newer results from up to NFWD later pipeline stages and detects use-before-ready hazards. Results are registered into the EX operand latch with stall/flush control. It sits between the ID/EX boundary and the ALU, and supplies store data to the memory stage.

## Interface
- XLEN, 32, datapath width
- AW, 5, register-address width
- NFWD, 2, number of forwarding sources; index 0 is the youngest stage (EX/MEM), higher indices are older
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  ID stage presents an instruction
- rs1, rs2  in  AW  source register addresses
- rd1, rd2  in  XLEN  register-file read data
- pc, imm  in  XLEN  instruction PC, sign-extended immediate
- asel  in  2  A source: 0 rs1-data, 1 pc, 2 zero, 3 reserved (treated as zero)
- bsel  in  2  B source: 0 rs2-data, 1 imm, 2 constant 4, 3 reserved (treated as zero)
- fwd_wen  in  NFWD  source i will write a register
- fwd_rd  in  NFWD*AW  destination address of source i, slice i at [i*AW +: AW]
- fwd_data  in  NFWD*XLEN  result of source i
- fwd_rdy  in  NFWD  fwd_data[i] is valid now (0 for a load still in flight)
- stall  in  1  hold the operand latch
- flush  in  1  kill the latched instruction
- hazard  out  1  combinational; upstream must hold ID and PC this cycle
- out_valid  out  1  latched operands are valid
- op_a, op_b  out  XLEN  latched ALU operands
- st_data  out  XLEN  latched forwarded rs2 value (for stores, independent of bsel)
- fwd_hits  out  2*NFWD  latched per-operand hit flags: bit i = rs1 hit on source i, bit NFWD+i = rs2 hit on source i

## Operation
- Forward resolution per source register r (rs1, rs2): choose the lowest i with fwd_wen[i]=1, fwd_rd[i]==r and r!=0. The value is fwd_data[i] if a match exists, else rd1/rd2. Register x0 is never forwarded and always reads rd value.
- Hazard: asserted when in_valid=1 and the winning match for rs1 (asel=0) or rs2 (any bsel, since rs2 feeds st_data) has fwd_rdy=0. A non-winning older match does not matter.
- A and B are selected from the resolved values per asel/bsel. st_data is always the resolved rs2.
- Latch update priority per rising edge: flush > stall > hazard > load.
  - flush: out_valid<=0; data regs keep their value.
  - stall: all registers hold. hazard is still reported.
  - hazard: bubble, out_valid<=0, data regs hold.
  - otherwise: out_valid<=in_valid; op_a, op_b, st_data and fwd_hits load.
- All arithmetic is pass-through. Constant 4 is zero-extended to XLEN.

## Timing
- Latency: one cycle from inputs to op_a/op_b/st_data/out_valid.
- hazard is purely combinational from the current inputs, with no register.
- Reset (rstn low, asynchronous): out_valid=0, op_a=0, op_b=0, st_data=0, fwd_hits=0. Reset takes effect mid-cycle regardless of stall/flush. The first load is on the first rising edge after rstn deasserts.
- in_valid=0 with no flush/stall loads out_valid=0. hazard is forced to 0 when in_valid=0.
- flush and stall asserted together: flush wins, out_valid goes to 0.
- Multiple sources matching the same register: the youngest (lowest index) wins, including when it is not ready (hazard), even if an older source is ready.
- Across a held hazard, resolution re-evaluates every cycle. Once fwd_rdy rises, the next edge loads normally.

## Test plan
- Reset: drive rstn=0 mid-cycle with out_valid=1 -> out_valid, op_a, op_b, st_data, fwd_hits all 0 immediately. First edge after release with in_valid=1, rs1=3, rd1=0x11, asel=0, bsel=1, imm=0x20 -> op_a=0x11, op_b=0x20.
- Forward priority: rs1=5, fwd_wen=2'b11, fwd_rd[0]=fwd_rd[1]=5, fwd_data[0]=0xAAAA, fwd_data[1]=0xBBBB, fwd_rdy=2'b11 -> op_a=0xAAAA, fwd_hits[0]=1. Clear source 0 -> op_a=0xBBBB, fwd_hits[1]=1.
- x0 guard: rs2=0, fwd_wen[0]=1, fwd_rd[0]=0, fwd_data[0]=0xDEAD, rd2=0, bsel=0 -> op_b=0, st_data=0, fwd_hits=0.
- Load-use: rs1=7 matches source 0 with fwd_rdy[0]=0 -> hazard=1, next edge out_valid=0. Raise fwd_rdy[0] with fwd_data[0]=0x1234 -> hazard=0, next edge out_valid=1, op_a=0x1234.
- Stall vs flush: latched op_a=0x55 with stall=1 and new inputs -> op_a stays 0x55, out_valid held. stall=1 and flush=1 together -> out_valid=0.
- Source modes: asel=1, pc=0x80, bsel=2 -> op_a=0x80, op_b=4. asel=2, bsel=3 -> op_a=0, op_b=0. Repeat with XLEN=64 and NFWD=3, checking priority among 3 sources.

Source files
------------

// File: rtl/alu_operand_stage.sv
// EX-side operand select: forwards results from later stages, flags use-before-ready hazards
// and registers A/B/store-data operands with flush/stall control.
module alu_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    input  logic [XLEN-1:0]      rd1,
    input  logic [XLEN-1:0]      rd2,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      imm,
    input  logic [1:0]           asel,
    input  logic [1:0]           bsel,
    input  logic [NFWD-1:0]      fwd_wen,
    input  logic [NFWD*AW-1:0]   fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_rdy,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 hazard,
    output logic                 out_valid,
    output logic [XLEN-1:0]      op_a,
    output logic [XLEN-1:0]      op_b,
    output logic [XLEN-1:0]      st_data,
    output logic [2*NFWD-1:0]    fwd_hits
);

    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic [NFWD-1:0]   rs1_hit, rs2_hit;
    logic              rs1_rdy, rs2_rdy;
    logic [XLEN-1:0]   a_sel, b_sel;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [XLEN-1:0]   st_data_q, st_data_d;
    logic [2*NFWD-1:0] hits_q, hits_d;

    // Walk from oldest to youngest so the lowest-index match overwrites and wins.
    always_comb begin
        rs1_val = rd1;
        rs2_val = rd2;
        rs1_hit = '0;
        rs2_hit = '0;
        rs1_rdy = 1'b1;
        rs2_rdy = 1'b1;
        for (int i = int'(NFWD) - 1; i >= 0; i--) begin
            if (fwd_wen[i] && (fwd_rd[i*AW +: AW] == rs1) && (rs1 != '0)) begin
                rs1_val    = fwd_data[i*XLEN +: XLEN];
                rs1_hit    = '0;
                rs1_hit[i] = 1'b1;
                rs1_rdy    = fwd_rdy[i];
            end
            if (fwd_wen[i] && (fwd_rd[i*AW +: AW] == rs2) && (rs2 != '0)) begin
                rs2_val    = fwd_data[i*XLEN +: XLEN];
                rs2_hit    = '0;
                rs2_hit[i] = 1'b1;
                rs2_rdy    = fwd_rdy[i];
            end
        end
    end

    // rs2 always counts: it feeds st_data regardless of bsel.
    assign hazard = in_valid && (((asel == 2'd0) && !rs1_rdy) || !rs2_rdy);

    always_comb begin
        unique case (asel)
            2'd0:    a_sel = rs1_val;
            2'd1:    a_sel = pc;
            default: a_sel = '0;
        endcase
        unique case (bsel)
            2'd0:    b_sel = rs2_val;
            2'd1:    b_sel = imm;
            2'd2:    b_sel = XLEN'(4);
            default: b_sel = '0;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        st_data_d = st_data_q;
        hits_d    = hits_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d = 1'b0;
        end else begin
            valid_d   = in_valid;
            op_a_d    = a_sel;
            op_b_d    = b_sel;
            st_data_d = rs2_val;
            hits_d    = {rs2_hit, rs1_hit};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            st_data_q <= '0;
            hits_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            st_data_q <= st_data_d;
            hits_q    <= hits_d;
        end
    end

    assign out_valid = valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign st_data   = st_data_q;
    assign fwd_hits  = hits_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: default 32-bit/2-source instance plus a 64-bit/3-source one.
module tb_alu_operand_stage;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: XLEN=32, NFWD=2
    logic        in_valid, stall, flush, hazard, out_valid;
    logic [4:0]  rs1, rs2;
    logic [31:0] rd1, rd2, pc, imm, op_a, op_b, st_data;
    logic [1:0]  asel, bsel, fwd_wen, fwd_rdy;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [3:0]  fwd_hits;

    alu_operand_stage dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .pc(pc), .imm(imm), .asel(asel), .bsel(bsel), .fwd_wen(fwd_wen), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .fwd_rdy(fwd_rdy), .stall(stall), .flush(flush), .hazard(hazard),
        .out_valid(out_valid), .op_a(op_a), .op_b(op_b), .st_data(st_data), .fwd_hits(fwd_hits)
    );

    // Instance B: XLEN=64, NFWD=3
    logic         b_in_valid, b_stall, b_flush, b_hazard, b_out_valid;
    logic [4:0]   b_rs1, b_rs2;
    logic [63:0]  b_rd1, b_rd2, b_pc, b_imm, b_op_a, b_op_b, b_st_data;
    logic [1:0]   b_asel, b_bsel;
    logic [2:0]   b_fwd_wen, b_fwd_rdy;
    logic [14:0]  b_fwd_rd;
    logic [191:0] b_fwd_data;
    logic [5:0]   b_fwd_hits;

    alu_operand_stage #(.XLEN(64), .AW(5), .NFWD(3)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .rs1(b_rs1), .rs2(b_rs2), .rd1(b_rd1),
        .rd2(b_rd2), .pc(b_pc), .imm(b_imm), .asel(b_asel), .bsel(b_bsel), .fwd_wen(b_fwd_wen),
        .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data), .fwd_rdy(b_fwd_rdy), .stall(b_stall),
        .flush(b_flush), .hazard(b_hazard), .out_valid(b_out_valid), .op_a(b_op_a),
        .op_b(b_op_b), .st_data(b_st_data), .fwd_hits(b_fwd_hits)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 0; stall = 0; flush = 0; rs1 = 0; rs2 = 0; rd1 = 0; rd2 = 0;
        pc = 0; imm = 0; asel = 0; bsel = 0; fwd_wen = 0; fwd_rdy = 0; fwd_rd = 0; fwd_data = 0;
        b_in_valid = 0; b_stall = 0; b_flush = 0; b_rs1 = 0; b_rs2 = 0; b_rd1 = 0; b_rd2 = 0;
        b_pc = 0; b_imm = 0; b_asel = 0; b_bsel = 0; b_fwd_wen = 0; b_fwd_rdy = 0;
        b_fwd_rd = 0; b_fwd_data = 0;
        #1;
        check("por_valid", 64'(out_valid), 64'd0);
        step(); step();
        rstn = 1'b1;

        // First load after reset
        in_valid = 1; rs1 = 3; rd1 = 32'h11; asel = 0; bsel = 1; imm = 32'h20;
        rs2 = 4; rd2 = 32'h44;
        step();
        check("load_valid", 64'(out_valid), 64'd1);
        check("load_op_a", 64'(op_a), 64'h11);
        check("load_op_b", 64'(op_b), 64'h20);

        // Asynchronous reset mid-cycle
        #2 rstn = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_op_a", 64'(op_a), 64'd0);
        check("rst_op_b", 64'(op_b), 64'd0);
        check("rst_st_data", 64'(st_data), 64'd0);
        check("rst_hits", 64'(fwd_hits), 64'd0);
        #1 rstn = 1'b1;
        step();
        check("post_rst_op_a", 64'(op_a), 64'h11);
        check("post_rst_op_b", 64'(op_b), 64'h20);
        check("post_rst_st", 64'(st_data), 64'h44);

        // Forward priority: youngest source wins
        rs1 = 5; rd1 = 32'h99; rs2 = 6; rd2 = 32'h66; asel = 0; bsel = 0;
        fwd_wen = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'hBBBB, 32'hAAAA}; fwd_rdy = 2'b11;
        #1;
        check("prio_no_hazard", 64'(hazard), 64'd0);
        step();
        check("prio_op_a", 64'(op_a), 64'hAAAA);
        check("prio_op_b", 64'(op_b), 64'h66);
        check("prio_hits", 64'(fwd_hits), 64'b0001);
        fwd_wen = 2'b10;
        step();
        check("older_op_a", 64'(op_a), 64'hBBBB);
        check("older_hits", 64'(fwd_hits), 64'b0010);

        // rs2 forwarding feeds both op_b and st_data
        rs2 = 5; fwd_wen = 2'b01;
        step();
        check("fwd_rs2_op_b", 64'(op_b), 64'hAAAA);
        check("fwd_rs2_st", 64'(st_data), 64'hAAAA);
        check("fwd_both_hits", 64'(fwd_hits), 64'b0101);

        // x0 is never forwarded
        rs1 = 1; rd1 = 32'h1; rs2 = 0; rd2 = 0; bsel = 0;
        fwd_wen = 2'b01; fwd_rd = {5'd9, 5'd0}; fwd_data = {32'h0, 32'hDEAD};
        step();
        check("x0_op_b", 64'(op_b), 64'd0);
        check("x0_st", 64'(st_data), 64'd0);
        check("x0_hits", 64'(fwd_hits), 64'd0);
        check("x0_op_a", 64'(op_a), 64'h1);

        // Load-use hazard then resolution
        rs1 = 7; rs2 = 8; rd2 = 32'h88;
        fwd_wen = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_data = 64'd0; fwd_rdy = 2'b00;
        #1;
        check("lu_hazard", 64'(hazard), 64'd1);
        step();
        check("lu_bubble", 64'(out_valid), 64'd0);
        check("lu_hold_op_a", 64'(op_a), 64'h1);
        fwd_rdy = 2'b01; fwd_data = {32'h0, 32'h1234};
        #1;
        check("lu_clear", 64'(hazard), 64'd0);
        step();
        check("lu_valid", 64'(out_valid), 64'd1);
        check("lu_op_a", 64'(op_a), 64'h1234);

        // Younger unready match hides a ready older one
        fwd_wen = 2'b11; fwd_rd = {5'd7, 5'd7}; fwd_rdy = 2'b10;
        #1;
        check("young_unready", 64'(hazard), 64'd1);
        // rs1 unused when asel!=0, but rs2 still counts with any bsel
        asel = 1;
        #1;
        check("rs1_unused", 64'(hazard), 64'd0);
        rs2 = 7; bsel = 1;
        #1;
        check("rs2_any_bsel", 64'(hazard), 64'd1);
        in_valid = 0;
        #1;
        check("hz_gated", 64'(hazard), 64'd0);
        step();
        check("idle_valid", 64'(out_valid), 64'd0);

        // Stall holds, stall+flush clears valid
        in_valid = 1; fwd_wen = 0; rs1 = 3; rd1 = 32'h55; asel = 0; rs2 = 4; rd2 = 32'h44;
        bsel = 0;
        step();
        check("pre_stall_op_a", 64'(op_a), 64'h55);
        stall = 1; rd1 = 32'h77; rd2 = 32'h78;
        step();
        check("stall_op_a", 64'(op_a), 64'h55);
        check("stall_st", 64'(st_data), 64'h44);
        check("stall_valid", 64'(out_valid), 64'd1);
        flush = 1;
        step();
        check("stflush_valid", 64'(out_valid), 64'd0);
        check("stflush_op_a", 64'(op_a), 64'h55);
        stall = 0; flush = 0;
        step();
        check("resume_op_a", 64'(op_a), 64'h77);
        flush = 1;
        step();
        check("flush_valid", 64'(out_valid), 64'd0);
        flush = 0;

        // Source modes
        asel = 1; pc = 32'h80; bsel = 2; rs2 = 8; rd2 = 32'h88;
        step();
        check("pc_op_a", 64'(op_a), 64'h80);
        check("four_op_b", 64'(op_b), 64'd4);
        check("st_indep", 64'(st_data), 64'h88);
        asel = 2; bsel = 3;
        step();
        check("zero_op_a", 64'(op_a), 64'd0);
        check("rsv_op_b", 64'(op_b), 64'd0);
        asel = 3;
        step();
        check("rsv_op_a", 64'(op_a), 64'd0);
        in_valid = 0;

        // 64-bit, 3-source instance
        b_in_valid = 1; b_rs1 = 9; b_rd1 = 64'h99; b_asel = 0; b_rs2 = 10;
        b_bsel = 1; b_imm = 64'hFFFF_FFFF_FFFF_FFF0;
        b_fwd_rd = {5'd9, 5'd9, 5'd9};
        b_fwd_data = {64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        b_fwd_wen = 3'b110; b_fwd_rdy = 3'b111;
        step();
        check("b_src1_op_a", b_op_a, 64'h2222_0000_0000_0002);
        check("b_src1_hits", 64'(b_fwd_hits), 64'b000010);
        check("b_imm_op_b", b_op_b, 64'hFFFF_FFFF_FFFF_FFF0);
        b_fwd_wen = 3'b100;
        step();
        check("b_src2_op_a", b_op_a, 64'h3333_0000_0000_0003);
        check("b_src2_hits", 64'(b_fwd_hits), 64'b000100);
        b_fwd_wen = 3'b111;
        step();
        check("b_src0_op_a", b_op_a, 64'h1111_0000_0000_0001);
        b_fwd_rdy = 3'b110;
        #1;
        check("b_young_hz", 64'(b_hazard), 64'd1);
        b_asel = 1; b_pc = 64'h8000_0000_0000_0080; b_bsel = 2; b_fwd_rdy = 3'b111;
        step();
        check("b_pc_op_a", b_op_a, 64'h8000_0000_0000_0080);
        check("b_four_op_b", b_op_b, 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
